ahb_arbiter: RTL and testbench
==============================

AHB_ARBITER -- requirements
Module: ahb_arbiter

Interface
REQ-001 SHALL have parameter NUM_MASTERS, default number_of_masters (2), number of requesting masters (1..16).
REQ-002 SHALL have parameter DEFAULT_MASTER, default 0, master granted when no request is pending.
REQ-003 SHALL have port HCLK  input  1  bus clock; the block uses one clock, all state updates on rising edge.
REQ-004 SHALL have port HRESETn  input  1  reset, asynchronous assert, active-low.
REQ-005 SHALL have port HBUSREQ  input  NUM_MASTERS  per-master bus request.
REQ-006 SHALL have port HLOCK  input  NUM_MASTERS  per-master locked-transfer request.
REQ-007 SHALL have port HTRANS  input  2  transfer type of the current bus owner (IDLE=0, BUSY=1, NONSEQ=2, SEQ=3).
REQ-008 SHALL have port HBURST  input  3  burst type of the current bus owner (SINGLE=0, INCR=1, WRAP4/INCR4=2/3, WRAP8/INCR8=4/5, WRAP16/INCR16=6/7).
REQ-009 SHALL have port HREADY  input  1  transfer-complete from the slave mux.
REQ-010 SHALL have port HRESP  input  2  slave response (OKAY=0, ERROR=1, RETRY=2, SPLIT=3).
REQ-011 SHALL have port HGRANT  output  NUM_MASTERS  one-hot grant.
REQ-012 SHALL have port HMASTER  output  4  index of the master owning the address phase.
REQ-013 SHALL have port HMASTLOCK  output  1  current address phase is locked.

Function
REQ-014 SHALL keep HGRANT one-hot at all times, reset included.
REQ-015 SHALL be an FSM with states ARB, BURST and LOCKED, registered on HCLK.
REQ-016 ARB: on HREADY=1, grant the first requesting master in round-robin order starting at (last granted index + 1) mod NUM_MASTERS; with no request, grant DEFAULT_MASTER.
REQ-017 ARB -> BURST when HREADY=1, HTRANS=NONSEQ and HBURST is a fixed-length burst (codes 2..7); load the beat counter with length-1 (3, 7 or 15).
REQ-018 BURST: decrement the counter on each HREADY=1 with HTRANS=SEQ; hold HGRANT; BUSY and HREADY=0 cycles do not decrement.
REQ-019 BURST -> ARB on the HREADY=1 cycle accepting the beat that brings the counter to 0; the new grant is visible on HGRANT the following cycle.
REQ-020 ARB/BURST -> LOCKED when the granted master's HLOCK=1 on an HREADY=1 cycle; LOCKED holds HGRANT regardless of other requests.
REQ-021 LOCKED -> ARB on the first HREADY=1 cycle with the owner's HLOCK=0 and HTRANS=IDLE.
REQ-022 INCR (undefined length) and SINGLE SHALL not enter BURST; re-arbitration is permitted on every HREADY=1 cycle.
REQ-023 HGRANT SHALL change only on rising edges where HREADY=1.
REQ-024 HMASTER SHALL load the index of the granted master on each rising edge with HREADY=1 (one cycle after HGRANT).
REQ-025 HMASTLOCK SHALL load the granted master's HLOCK on each rising edge with HREADY=1.
REQ-026 HRESP=ERROR or RETRY with HREADY=0 SHALL clear the beat counter and force BURST -> ARB; LOCKED is unaffected.
REQ-027 HRESP=SPLIT SHALL be treated as RETRY; split masking is not supported.
REQ-028 Simultaneous requests with the owner still requesting SHALL pass grant to the next requester in round-robin order (no starvation).

Reset
REQ-029 While HRESETn=0: state=ARB, HGRANT=one-hot(DEFAULT_MASTER), HMASTER=DEFAULT_MASTER, HMASTLOCK=0, counter=0, round-robin pointer=DEFAULT_MASTER.
REQ-030 Reset asserted mid-burst or mid-lock SHALL abandon it immediately, with no residual state after deassertion.
REQ-031 Release SHALL be synchronous to HCLK; the first arbitration occurs on the first HREADY=1 edge after release.

Structure
REQ-032 The shared package ahb_parameters SHALL hold the arbiter state enum, the HTRANS/HBURST/HRESP encodings and the burst-length constants; NUM_MASTERS SHALL default from number_of_masters.
REQ-033 A single sub-module ahb_rr_select SHALL compute combinationally the next round-robin winner from request vector and pointer.

Verification
REQ-034 Reset, no requests, HREADY=1 -> HGRANT=01, HMASTER=0, HMASTLOCK=0 each cycle.
REQ-035 M0 and M1 both request continuously with SINGLE NONSEQ transfers -> HGRANT alternates 01,10,01 each HREADY cycle; HMASTER follows one cycle later.
REQ-036 M1 granted issues INCR4, M0 requests throughout -> HGRANT stays 10 for 4 accepted beats, becomes 01 the cycle after the 4th beat is accepted.
REQ-037 INCR8 with 2 HREADY=0 wait cycles at beat 3 -> grant held for 8 accepted beats plus 2 waits (10 cycles).
REQ-038 M0 asserts HLOCK, M1 requests -> HGRANT stays 01, HMASTLOCK=1, until M0 drops HLOCK and drives IDLE, then HGRANT=10.
REQ-039 RETRY (HREADY=0) at beat 2 of INCR16 with M1 requesting -> counter cleared, HGRANT=10 on the next HREADY=1 edge.

Source files
------------

// File: rtl/ahb_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// ahb_parameters : arbiter state enum, AHB bus encodings, burst lengths
// Rev 1.0
// ============================================================================
package ahb_parameters;

  localparam int number_of_masters = 2;

  typedef enum logic [1:0] {
    ST_ARB    = 2'd0,
    ST_BURST  = 2'd1,
    ST_LOCKED = 2'd2
  } arb_state_e;

  localparam logic [1:0] HTRANS_IDLE   = 2'd0;
  localparam logic [1:0] HTRANS_BUSY   = 2'd1;
  localparam logic [1:0] HTRANS_NONSEQ = 2'd2;
  localparam logic [1:0] HTRANS_SEQ    = 2'd3;

  localparam logic [2:0] HBURST_SINGLE = 3'd0;
  localparam logic [2:0] HBURST_INCR   = 3'd1;
  localparam logic [2:0] HBURST_WRAP4  = 3'd2;
  localparam logic [2:0] HBURST_INCR4  = 3'd3;
  localparam logic [2:0] HBURST_WRAP8  = 3'd4;
  localparam logic [2:0] HBURST_INCR8  = 3'd5;
  localparam logic [2:0] HBURST_WRAP16 = 3'd6;
  localparam logic [2:0] HBURST_INCR16 = 3'd7;

  localparam logic [1:0] HRESP_OKAY  = 2'd0;
  localparam logic [1:0] HRESP_ERROR = 2'd1;
  localparam logic [1:0] HRESP_RETRY = 2'd2;
  localparam logic [1:0] HRESP_SPLIT = 2'd3;

  // Beats remaining after the NONSEQ beat of each fixed-length burst.
  localparam logic [3:0] LAST_BEAT_4  = 4'd3;
  localparam logic [3:0] LAST_BEAT_8  = 4'd7;
  localparam logic [3:0] LAST_BEAT_16 = 4'd15;

  function automatic logic is_fixed_burst(input logic [2:0] hburst);
    return hburst >= HBURST_WRAP4;
  endfunction

  function automatic logic [3:0] last_beat(input logic [2:0] hburst);
    case (hburst)
      HBURST_WRAP4,  HBURST_INCR4:  return LAST_BEAT_4;
      HBURST_WRAP8,  HBURST_INCR8:  return LAST_BEAT_8;
      HBURST_WRAP16, HBURST_INCR16: return LAST_BEAT_16;
      default:                      return 4'd0;
    endcase
  endfunction

endpackage
`default_nettype wire

// File: rtl/ahb_arbiter_rr_select.sv
`default_nettype none
// ============================================================================
// ahb_rr_select : combinational round-robin winner search from ptr+1 onwards
// Rev 1.0
// ============================================================================
module ahb_rr_select
  import ahb_parameters::*;
#(
  parameter int NUM_MASTERS    = number_of_masters,
  parameter int DEFAULT_MASTER = 0
) (
  input  logic [NUM_MASTERS-1:0] req,
  input  logic [3:0]             ptr,
  output logic [3:0]             winner
);

  logic [4:0] cand;
  logic       found;

  always_comb begin
    winner = 4'(DEFAULT_MASTER);
    found  = 1'b0;
    cand   = 5'd0;
    for (int i = 0; i < NUM_MASTERS; i++) begin
      // ptr is always below NUM_MASTERS, so one wrap subtraction suffices.
      cand = {1'b0, ptr} + 5'(i) + 5'd1;
      if (cand >= 5'(NUM_MASTERS)) begin
        cand = cand - 5'(NUM_MASTERS);
      end
      for (int j = 0; j < NUM_MASTERS; j++) begin
        if (!found && (cand == 5'(j)) && req[j]) begin
          winner = 4'(j);
          found  = 1'b1;
        end
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/ahb_arbiter.sv
`default_nettype none
// ============================================================================
// ahb_arbiter : AHB round-robin bus arbiter with fixed-burst and lock holding
// Rev 1.0
// ============================================================================
module ahb_arbiter
  import ahb_parameters::*;
#(
  parameter int NUM_MASTERS    = number_of_masters,
  parameter int DEFAULT_MASTER = 0
) (
  input  logic                   HCLK,
  input  logic                   HRESETn,
  input  logic [NUM_MASTERS-1:0] HBUSREQ,
  input  logic [NUM_MASTERS-1:0] HLOCK,
  input  logic [1:0]             HTRANS,
  input  logic [2:0]             HBURST,
  input  logic                   HREADY,
  input  logic [1:0]             HRESP,
  output logic [NUM_MASTERS-1:0] HGRANT,
  output logic [3:0]             HMASTER,
  output logic                   HMASTLOCK
);

  localparam logic [3:0] DEFAULT_IDX = 4'(DEFAULT_MASTER);

  arb_state_e             state_q, state_d;
  logic [3:0]             owner_q, owner_d;
  logic [3:0]             cnt_q, cnt_d;
  logic [NUM_MASTERS-1:0] grant_q, grant_d;
  logic [NUM_MASTERS-1:0] default_grant;
  logic [3:0]             hmaster_q, hmaster_d;
  logic                   hmastlock_q, hmastlock_d;
  logic [3:0]             rr_winner;
  logic                   owner_lock;
  logic                   rearb;
  logic                   err_abort;

  // owner_q doubles as the round-robin pointer: it is the last granted index.
  ahb_rr_select #(
    .NUM_MASTERS    (NUM_MASTERS),
    .DEFAULT_MASTER (DEFAULT_MASTER)
  ) u_rr_select (
    .req    (HBUSREQ),
    .ptr    (owner_q),
    .winner (rr_winner)
  );

  always_comb begin
    owner_lock    = 1'b0;
    default_grant = '0;
    for (int i = 0; i < NUM_MASTERS; i++) begin
      if (owner_q == 4'(i)) begin
        owner_lock = HLOCK[i];
      end
      default_grant[i] = (DEFAULT_IDX == 4'(i));
    end
  end

  assign err_abort = !HREADY && (HRESP != HRESP_OKAY);

  always_comb begin
    state_d     = state_q;
    owner_d     = owner_q;
    cnt_d       = cnt_q;
    hmaster_d   = hmaster_q;
    hmastlock_d = hmastlock_q;
    rearb       = 1'b0;

    if (HREADY) begin
      hmaster_d   = owner_q;
      hmastlock_d = owner_lock;
    end

    case (state_q)
      ST_ARB: begin
        if (HREADY) begin
          if (owner_lock) begin
            state_d = ST_LOCKED;
          end else if ((HTRANS == HTRANS_NONSEQ) && is_fixed_burst(HBURST)) begin
            state_d = ST_BURST;
            cnt_d   = last_beat(HBURST);
          end else begin
            rearb = 1'b1;
          end
        end
      end
      ST_BURST: begin
        // A two-cycle ERROR/RETRY/SPLIT response abandons the burst; the
        // grant itself can only move on the following HREADY edge.
        if (err_abort) begin
          state_d = ST_ARB;
          cnt_d   = 4'd0;
        end else if (HREADY) begin
          if (owner_lock) begin
            state_d = ST_LOCKED;
            cnt_d   = 4'd0;
          end else if (HTRANS == HTRANS_SEQ) begin
            if (cnt_q <= 4'd1) begin
              state_d = ST_ARB;
              cnt_d   = 4'd0;
              rearb   = 1'b1;
            end else begin
              cnt_d = cnt_q - 4'd1;
            end
          end
        end
      end
      ST_LOCKED: begin
        if (HREADY && !owner_lock && (HTRANS == HTRANS_IDLE)) begin
          state_d = ST_ARB;
          rearb   = 1'b1;
        end
      end
      default: begin
        state_d = ST_ARB;
        cnt_d   = 4'd0;
      end
    endcase

    if (rearb) begin
      owner_d = rr_winner;
    end

    grant_d = '0;
    for (int i = 0; i < NUM_MASTERS; i++) begin
      grant_d[i] = (owner_d == 4'(i));
    end
  end

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      state_q     <= ST_ARB;
      owner_q     <= DEFAULT_IDX;
      cnt_q       <= 4'd0;
      grant_q     <= default_grant;
      hmaster_q   <= DEFAULT_IDX;
      hmastlock_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      owner_q     <= owner_d;
      cnt_q       <= cnt_d;
      grant_q     <= grant_d;
      hmaster_q   <= hmaster_d;
      hmastlock_q <= hmastlock_d;
    end
  end

  assign HGRANT    = grant_q;
  assign HMASTER   = hmaster_q;
  assign HMASTLOCK = hmastlock_q;

endmodule
`default_nettype wire

// File: tb/tb_ahb_arbiter.sv
`default_nettype none
// ============================================================================
// tb_ahb_arbiter : directed scenarios plus random traffic against a
//                  beat-counting reference model of the arbitration rules
// Rev 1.0
// ============================================================================
module tb_ahb_arbiter;

  localparam int N = 2;

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] NONSEQ = 2'd2;
  localparam logic [1:0] SEQ    = 2'd3;
  localparam logic [2:0] SINGLE = 3'd0;
  localparam logic [2:0] INCR4  = 3'd3;
  localparam logic [2:0] INCR8  = 3'd5;
  localparam logic [2:0] INCR16 = 3'd7;
  localparam logic [1:0] OKAY   = 2'd0;
  localparam logic [1:0] RETRY  = 2'd2;

  logic         hclk = 1'b0;
  logic         hresetn;
  logic [N-1:0] hbusreq;
  logic [N-1:0] hlock;
  logic [1:0]   htrans;
  logic [2:0]   hburst;
  logic         hready;
  logic [1:0]   hresp;
  logic [N-1:0] hgrant;
  logic [3:0]   hmaster;
  logic         hmastlock;

  always #5 hclk = ~hclk;

  ahb_arbiter #(
    .NUM_MASTERS    (N),
    .DEFAULT_MASTER (0)
  ) dut (
    .HCLK      (hclk),
    .HRESETn   (hresetn),
    .HBUSREQ   (hbusreq),
    .HLOCK     (hlock),
    .HTRANS    (htrans),
    .HBURST    (hburst),
    .HREADY    (hready),
    .HRESP     (hresp),
    .HGRANT    (hgrant),
    .HMASTER   (hmaster),
    .HMASTLOCK (hmastlock)
  );

  int n_cmp = 0;
  int n_err = 0;

  // Reference model: who owns the grant, how many beats of a fixed burst
  // are still owed, and whether the owner holds a lock.
  int m_owner;
  int m_left;
  bit m_locked;
  int m_hmaster;
  bit m_hmastlock;
  int burst_len [8] = '{1, 1, 4, 4, 8, 8, 16, 16};

  function automatic bit bit_of(input int unsigned v, input int i);
    return ((v >> i) & 1) != 0;
  endfunction

  function automatic int rr_pick(input int last, input int unsigned req);
    for (int k = 1; k <= N; k++) begin
      if (bit_of(req, (last + k) % N)) return (last + k) % N;
    end
    return 0;
  endfunction

  task automatic model_reset();
    m_owner     = 0;
    m_left      = 0;
    m_locked    = 1'b0;
    m_hmaster   = 0;
    m_hmastlock = 1'b0;
  endtask

  task automatic model_edge();
    bit rearb;
    bit own_lock;
    rearb    = 1'b0;
    own_lock = bit_of(int'(hlock), m_owner);
    if (hready) begin
      m_hmaster   = m_owner;
      m_hmastlock = own_lock;
    end
    if (m_locked) begin
      if (hready && !own_lock && htrans == IDLE) begin
        m_locked = 1'b0;
        rearb    = 1'b1;
      end
    end else if (m_left > 0) begin
      if (!hready) begin
        if (hresp != OKAY) m_left = 0;
      end else if (own_lock) begin
        m_locked = 1'b1;
        m_left   = 0;
      end else if (htrans == SEQ) begin
        m_left = m_left - 1;
        rearb  = (m_left == 0);
      end
    end else if (hready) begin
      if (own_lock) m_locked = 1'b1;
      else if (htrans == NONSEQ && burst_len[hburst] > 1) m_left = burst_len[hburst] - 1;
      else rearb = 1'b1;
    end
    if (rearb) m_owner = rr_pick(m_owner, int'(hbusreq));
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_model(input string where);
    logic [N-1:0] eg;
    eg = N'(1) << m_owner;
    chk({where, "/hgrant"},    32'(hgrant),    32'(eg));
    chk({where, "/hmaster"},   32'(hmaster),   32'(m_hmaster));
    chk({where, "/hmastlock"}, 32'(hmastlock), 32'(m_hmastlock));
  endtask

  task automatic step(input string where);
    @(posedge hclk);
    model_edge();
    @(negedge hclk);
    check_model(where);
  endtask

  initial begin
    hresetn = 1'b0;
    hbusreq = '0;
    hlock   = '0;
    htrans  = IDLE;
    hburst  = SINGLE;
    hready  = 1'b1;
    hresp   = OKAY;
    model_reset();

    // Reset state
    repeat (2) @(negedge hclk);
    chk("rst/hgrant",    32'(hgrant),    32'h1);
    chk("rst/hmaster",   32'(hmaster),   32'h0);
    chk("rst/hmastlock", 32'(hmastlock), 32'h0);
    hresetn = 1'b1;

    // No requests: default master parked
    for (int i = 0; i < 4; i++) begin
      step("idle");
      chk("idle/hgrant",  32'(hgrant),  32'h1);
      chk("idle/hmaster", 32'(hmaster), 32'h0);
    end

    // Both request SINGLE transfers: grant alternates, HMASTER lags one cycle
    hbusreq = 2'b11;
    htrans  = NONSEQ;
    hburst  = SINGLE;
    for (int i = 0; i < 6; i++) begin
      step("single");
      chk("single/hgrant",  32'(hgrant),  (i % 2 == 0) ? 32'h2 : 32'h1);
      chk("single/hmaster", 32'(hmaster), (i % 2 == 0) ? 32'h0 : 32'h1);
    end

    // M1 takes the bus, then runs INCR4 while M0 keeps requesting
    hbusreq = 2'b10;
    htrans  = IDLE;
    step("incr4_setup");
    chk("incr4_setup/hgrant", 32'(hgrant), 32'h2);
    hbusreq = 2'b11;
    htrans  = NONSEQ;
    hburst  = INCR4;
    step("incr4_b1");
    chk("incr4_b1/hgrant", 32'(hgrant), 32'h2);
    htrans = SEQ;
    for (int b = 2; b <= 4; b++) begin
      step("incr4");
      chk("incr4/hgrant", 32'(hgrant), (b == 4) ? 32'h1 : 32'h2);
    end

    // INCR8 by M0 with two wait states on beat 3: 10 held cycles
    htrans = NONSEQ;
    hburst = INCR8;
    for (int c = 1; c <= 10; c++) begin
      hready = !(c == 3 || c == 4);
      step("incr8");
      chk("incr8/hgrant", 32'(hgrant), (c == 10) ? 32'h2 : 32'h1);
      htrans = SEQ;
    end
    hready = 1'b1;

    // M0 locks the bus while M1 requests
    hbusreq = 2'b01;
    hlock   = 2'b01;
    htrans  = IDLE;
    hburst  = SINGLE;
    step("lock_setup");
    step("lock_enter");
    chk("lock_enter/hgrant", 32'(hgrant), 32'h1);
    hbusreq = 2'b11;
    htrans  = NONSEQ;
    for (int i = 0; i < 3; i++) begin
      step("locked");
      chk("locked/hgrant",    32'(hgrant),    32'h1);
      chk("locked/hmastlock", 32'(hmastlock), 32'h1);
    end
    hlock  = 2'b00;
    htrans = IDLE;
    step("unlock");
    chk("unlock/hgrant", 32'(hgrant), 32'h2);

    // RETRY on beat 2 of an INCR16 from M0, M1 waiting
    hbusreq = 2'b01;
    step("retry_setup");
    chk("retry_setup/hgrant", 32'(hgrant), 32'h1);
    hbusreq = 2'b11;
    htrans  = NONSEQ;
    hburst  = INCR16;
    step("retry_b1");
    htrans = SEQ;
    hready = 1'b0;
    hresp  = RETRY;
    step("retry_wait");
    chk("retry_wait/hgrant", 32'(hgrant), 32'h1);
    hready = 1'b1;
    htrans = IDLE;
    step("retry_done");
    chk("retry_done/hgrant", 32'(hgrant), 32'h2);
    hresp = OKAY;

    // Asynchronous reset in the middle of an M1 INCR8
    htrans = NONSEQ;
    hburst = INCR8;
    step("rstburst_b1");
    htrans = SEQ;
    step("rstburst_b2");
    chk("rstburst_b2/hgrant", 32'(hgrant), 32'h2);
    #2 hresetn = 1'b0;
    #1;
    chk("async_rst/hgrant",    32'(hgrant),    32'h1);
    chk("async_rst/hmaster",   32'(hmaster),   32'h0);
    chk("async_rst/hmastlock", 32'(hmastlock), 32'h0);
    @(negedge hclk);
    hresetn = 1'b1;
    model_reset();
    hbusreq = 2'b10;
    step("post_rst");
    chk("post_rst/hgrant", 32'(hgrant), 32'h2);

    // Random traffic against the model
    for (int i = 0; i < 500; i++) begin
      hbusreq = N'($urandom_range(0, 3));
      hlock   = ($urandom_range(0, 7) == 0) ? N'($urandom_range(1, 3)) : '0;
      htrans  = 2'($urandom_range(0, 3));
      hburst  = 3'($urandom_range(0, 7));
      hready  = ($urandom_range(0, 3) != 0);
      hresp   = ($urandom_range(0, 7) == 0) ? 2'($urandom_range(1, 3)) : OKAY;
      step("rand");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire
